sram_1p_ctrl: RTL and testbench



---
 rtl/sram_1p_ctrl_if.sv | 35 +++
 rtl/sram_1p_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_1p_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1p_ctrl_if.sv
// Request/response channels between an initiator and sram_1p_ctrl:
// write and read request channels plus the read response channel.
interface sram_1p_ctrl_if #(
    parameter int DATA_W = 80,
    parameter int ADDR_W = 5
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd_valid, rd_addr,
        input  rd_ready,
        input  resp_valid, resp_data,
        output resp_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd_valid, rd_addr,
        output rd_ready,
        output resp_valid, resp_data,
        input  resp_ready
    );
endinterface

// File: rtl/sram_1p_ctrl.sv
// Round-robin write/read front end for a single-port SRAM macro with a held read response.
// Define SRAM_RESET_INIT_EN to add a zero sweep of the whole array after reset.
module sram_1p_ctrl #(
    parameter int DATA_W = 80,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RSTB,
    sram_1p_ctrl_if.slave     bus,
    output logic              init_done,
    output logic              SRAM_CEB,
    output logic              SRAM_WEB,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [DATA_W-1:0] SRAM_D,
    input  logic [DATA_W-1:0] SRAM_Q
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;
    typedef enum logic [0:0] {GR_WR, GR_RD} grant_t;

    state_t            state_reg;
    grant_t            last_grant_reg, last_grant_next;
    logic              inflight_reg, inflight_next;
    logic              hold_valid_reg, hold_valid_next;
    logic [DATA_W-1:0] hold_data_reg, hold_data_next;
    logic [DATA_W-1:0] resp_data_mux;

    logic run_active;
    logic rd_ok;
    logic wr_blocked;
    logic grant_wr;
    logic grant_rd;

`ifdef SRAM_RESET_INIT_EN
    state_t            state_next;
    logic [ADDR_W-1:0] init_cnt_reg, init_cnt_next;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        if (state_reg == ST_INIT) begin
            init_cnt_next = init_cnt_reg + ADDR_W'(1);
            if (init_cnt_reg == ADDR_MASK) begin
                state_next = ST_RUN;
            end
        end
    end
`else
    assign state_reg = ST_RUN;
`endif

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            last_grant_reg <= GR_RD;
            inflight_reg   <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else begin
            last_grant_reg <= last_grant_next;
            inflight_reg   <= inflight_next;
            hold_valid_reg <= hold_valid_next;
            hold_data_reg  <= hold_data_next;
        end
    end

    // Readiness is gated by RSTB so nothing reaches the macro while reset is held.
    always_comb begin
        run_active   = (state_reg == ST_RUN) && RSTB;
        rd_ok        = !hold_valid_reg && (!inflight_reg || bus.resp_ready);
        wr_blocked   = bus.rd_valid && rd_ok && (last_grant_reg == GR_WR);
        bus.wr_ready = run_active && !wr_blocked;
        bus.rd_ready = run_active && rd_ok && !(bus.wr_valid && (last_grant_reg == GR_RD));
        grant_wr     = bus.wr_valid && bus.wr_ready;
        grant_rd     = bus.rd_valid && bus.rd_ready;

        SRAM_CEB = 1'b1;
        SRAM_WEB = 1'b1;
        SRAM_A   = '0;
        SRAM_D   = '0;
        if (grant_wr) begin
            SRAM_CEB = 1'b0;
            SRAM_WEB = 1'b0;
            SRAM_A   = bus.wr_addr & ADDR_MASK;
            SRAM_D   = bus.wr_data;
        end else if (grant_rd) begin
            SRAM_CEB = 1'b0;
            SRAM_A   = bus.rd_addr & ADDR_MASK;
        end
`ifdef SRAM_RESET_INIT_EN
        if (RSTB && (state_reg == ST_INIT)) begin
            SRAM_CEB = 1'b0;
            SRAM_WEB = 1'b0;
            SRAM_A   = init_cnt_reg;
            SRAM_D   = '0;
        end
`endif

        last_grant_next = last_grant_reg;
        if (grant_wr) begin
            last_grant_next = GR_WR;
        end else if (grant_rd) begin
            last_grant_next = GR_RD;
        end

        // Q is only valid for one cycle, so a stalled response must be captured now.
        inflight_next   = grant_rd;
        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
        if (hold_valid_reg) begin
            if (bus.resp_ready) begin
                hold_valid_next = 1'b0;
            end
        end else if (inflight_reg && !bus.resp_ready) begin
            hold_valid_next = 1'b1;
            hold_data_next  = SRAM_Q;
        end
    end

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_resp_mux
        assign resp_data_mux[gi] = hold_valid_reg ? hold_data_reg[gi] : SRAM_Q[gi];
    end

    assign bus.resp_valid = inflight_reg || hold_valid_reg;
    assign bus.resp_data  = resp_data_mux;
    assign init_done      = (state_reg == ST_RUN);

endmodule

// File: tb/tb_sram_1p_ctrl.sv
// Self-checking bench for sram_1p_ctrl: behavioural macro, reference memory and response queue.
// Builds with or without SRAM_RESET_INIT_EN.
module tb_sram_1p_ctrl;

    localparam int DATA_W = 80;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic CLK  = 1'b0;
    logic RSTB = 1'b0;
    always #5 CLK = ~CLK;

    sram_1p_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    logic              init_done;
    logic              SRAM_CEB;
    logic              SRAM_WEB;
    logic [ADDR_W-1:0] SRAM_A;
    logic [DATA_W-1:0] SRAM_D;
    logic [DATA_W-1:0] SRAM_Q;

    sram_1p_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .bus       (bus),
        .init_done (init_done),
        .SRAM_CEB  (SRAM_CEB),
        .SRAM_WEB  (SRAM_WEB),
        .SRAM_A    (SRAM_A),
        .SRAM_D    (SRAM_D),
        .SRAM_Q    (SRAM_Q)
    );

    function automatic logic [DATA_W-1:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Behavioural macro: Q is garbage after any edge that is not a read.
    logic [DATA_W-1:0] macro_mem [DEPTH];
    logic [DATA_W-1:0] macro_q;
    always @(posedge CLK) begin
        if (!SRAM_CEB && !SRAM_WEB) begin
            macro_mem[SRAM_A] <= SRAM_D;
            macro_q           <= rand80();
        end else if (!SRAM_CEB) begin
            macro_q <= macro_mem[SRAM_A];
        end else begin
            macro_q <= rand80();
        end
    end
    assign SRAM_Q = macro_q;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    // One bus cycle: drive at posedge+1, observe at negedge, update the reference on handshakes.
    task automatic drive_cycle(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input logic rv, input logic [ADDR_W-1:0] ra, input logic rr,
                               output logic w_hs, output logic r_hs, output logic rsp_v,
                               output logic [DATA_W-1:0] rsp_d, output logic web, output int pend);
        bus.wr_valid   = wv;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.rd_valid   = rv;
        bus.rd_addr    = ra;
        bus.resp_ready = rr;
        @(negedge CLK);
        w_hs  = wv && bus.wr_ready;
        r_hs  = rv && bus.rd_ready;
        rsp_v = bus.resp_valid;
        rsp_d = bus.resp_data;
        web   = SRAM_WEB;
        pend  = exp_q.size();
        if (w_hs) begin
            ref_mem[wa] = wd;
            $display("write addr=%0d data=%h", wa, wd);
        end
        if (r_hs) begin
            exp_q.push_back(ref_mem[ra]);
            $display("read  addr=%0d", ra);
        end
        if (rsp_v && rr) $display("resp  data=%h", rsp_d);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic exp_init;
`ifdef SRAM_RESET_INIT_EN
        exp_init = 1'b0;
`else
        exp_init = 1'b1;
`endif
        RSTB = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_valid = 1'b1; bus.rd_addr = '0; bus.resp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (SRAM_CEB !== 1'b1 || SRAM_WEB !== 1'b1 || SRAM_A !== '0 || SRAM_D !== '0) begin
            errors++;
            $display("FAIL reset_macro got ceb=%b web=%b a=%0d d=%h exp ceb=1 web=1 a=0 d=0",
                     SRAM_CEB, SRAM_WEB, SRAM_A, SRAM_D);
        end
        checks++;
        if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake got wr_ready=%b rd_ready=%b resp_valid=%b exp 0 0 0",
                     bus.wr_ready, bus.rd_ready, bus.resp_valid);
        end
        checks++;
        if (init_done !== exp_init) begin
            errors++;
            $display("FAIL reset_init_done got=%b exp=%b", init_done, exp_init);
        end
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_release();
        logic w_hs, r_hs, rsp_v, web;
        logic [DATA_W-1:0] rsp_d;
        int pend;
        RSTB = 1'b1;
`ifdef SRAM_RESET_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            checks++;
            if (SRAM_CEB !== 1'b0 || SRAM_WEB !== 1'b0 || SRAM_A !== ADDR_W'(i) || SRAM_D !== '0 ||
                init_done !== 1'b0 || bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin
                errors++;
                $display("FAIL init_sweep step %0d got ceb=%b web=%b a=%0d d=%h done=%b wr_rdy=%b rd_rdy=%b exp 0 0 %0d 0 0 0 0",
                         i, SRAM_CEB, SRAM_WEB, SRAM_A, SRAM_D, init_done, bus.wr_ready, bus.rd_ready, i);
            end
        end
        @(negedge CLK);
        checks++;
        if (init_done !== 1'b1 || SRAM_CEB !== 1'b1) begin
            errors++;
            $display("FAIL init_done_rise got done=%b ceb=%b exp done=1 ceb=1", init_done, SRAM_CEB);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge CLK);
        #1;
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd7, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (r_hs !== 1'b1) begin errors++; $display("FAIL init_read7_accept got=%b exp=1", r_hs); end
        drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== '0) begin
            errors++;
            $display("FAIL init_read7_data got valid=%b data=%h exp valid=1 data=0", rsp_v, rsp_d);
        end
        if (rsp_v === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
`else
        @(negedge CLK);
        checks++;
        if (init_done !== 1'b1 || bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b1 || SRAM_CEB !== 1'b1) begin
            errors++;
            $display("FAIL release_run got done=%b wr_rdy=%b rd_rdy=%b ceb=%b exp 1 1 1 1",
                     init_done, bus.wr_ready, bus.rd_ready, SRAM_CEB);
        end
        @(posedge CLK);
        #1;
`endif
    endtask

    task automatic test_fill();
        logic w_hs, r_hs, rsp_v, web;
        logic [DATA_W-1:0] rsp_d;
        int pend;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, ADDR_W'(i), rand80(), 1'b0, '0, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
            checks++;
            if (w_hs !== 1'b1 || web !== 1'b0) begin
                errors++;
                $display("FAIL fill_write addr %0d got accept=%b web=%b exp 1 0", i, w_hs, web);
            end
        end
    endtask

    task automatic test_write_read();
        logic w_hs, r_hs, rsp_v, web;
        logic [DATA_W-1:0] rsp_d;
        int pend;
        drive_cycle(1'b1, 5'd3, 80'h1234, 1'b0, '0, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (w_hs !== 1'b1) begin errors++; $display("FAIL wr_rd_write_accept got=%b exp=1", w_hs); end
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd3, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (r_hs !== 1'b1 || rsp_v !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_read_accept got accept=%b valid=%b exp 1 0", r_hs, rsp_v);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== 80'h1234) begin
            errors++;
            $display("FAIL wr_rd_data got valid=%b data=%h exp valid=1 data=1234", rsp_v, rsp_d);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (rsp_v !== 1'b0) begin errors++; $display("FAIL wr_rd_single_beat got valid=%b exp=0", rsp_v); end
    endtask

    task automatic test_backpressure();
        logic w_hs, r_hs, rsp_v, web;
        logic [DATA_W-1:0] rsp_d, exp_d;
        int pend;
        drive_cycle(1'b1, 5'd5, 80'hAA, 1'b0, '0, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd5, 1'b0, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (r_hs !== 1'b1) begin errors++; $display("FAIL bp_read_accept got=%b exp=1", r_hs); end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, w_hs, r_hs, rsp_v, rsp_d, web, pend);
            checks++;
            if (rsp_v !== 1'b1 || rsp_d !== 80'hAA || r_hs !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b data=%h rd_accept=%b exp 1 aa 0", k, rsp_v, rsp_d, r_hs);
            end
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd9, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== 80'hAA || r_hs !== 1'b0) begin
            errors++;
            $display("FAIL bp_retire got valid=%b data=%h rd_accept=%b exp 1 aa 0", rsp_v, rsp_d, r_hs);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd9, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (rsp_v !== 1'b0 || r_hs !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_retire got valid=%b rd_accept=%b exp 0 1", rsp_v, r_hs);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (rsp_v !== 1'b1 || rsp_d !== exp_d) begin
            errors++;
            $display("FAIL bp_next_read got valid=%b data=%h exp valid=1 data=%h", rsp_v, rsp_d, exp_d);
        end
    endtask

    task automatic test_arbitration();
        logic w_hs, r_hs, rsp_v, web, exp_w;
        logic [DATA_W-1:0] rsp_d, exp_d, wd;
        logic [ADDR_W-1:0] wa, ra;
        int pend;
        // A lone read first leaves the write side owed the next tie.
        drive_cycle(1'b0, '0, '0, 1'b1, 5'($urandom), 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (r_hs !== 1'b1) begin errors++; $display("FAIL arb_pre_read got=%b exp=1", r_hs); end
        wa = 5'($urandom); ra = 5'($urandom); wd = rand80();
        for (int k = 0; k <= 6; k++) begin
            drive_cycle(k < 6, wa, wd, k < 6, ra, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
            exp_w = ((k % 2) == 0);
            if (k < 6) begin
                checks++;
                if (w_hs !== exp_w || r_hs !== !exp_w || web !== !exp_w) begin
                    errors++;
                    $display("FAIL arb_grant cycle %0d got w=%b r=%b web=%b exp w=%b r=%b web=%b",
                             k, w_hs, r_hs, web, exp_w, !exp_w, !exp_w);
                end
            end
            checks++;
            if (rsp_v !== (pend != 0)) begin
                errors++;
                $display("FAIL arb_resp_valid cycle %0d got=%b exp=%b", k, rsp_v, pend != 0);
            end else if (rsp_v) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (rsp_d !== exp_d) begin
                    errors++;
                    $display("FAIL arb_resp_data cycle %0d got=%h exp=%h", k, rsp_d, exp_d);
                end
            end
            if (w_hs) begin wa = 5'($urandom); wd = rand80(); end
            if (r_hs) ra = 5'($urandom);
        end
    endtask

    task automatic test_streaming();
        logic w_hs, r_hs, rsp_v, web, exp_r;
        logic [DATA_W-1:0] rsp_d, exp_d;
        int pend;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, ADDR_W'(i), rand80(), 1'b0, '0, 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
            checks++;
            if (w_hs !== 1'b1) begin errors++; $display("FAIL stream_write %0d got=%b exp=1", i, w_hs); end
        end
        for (int i = 0; i <= 9; i++) begin
            exp_r = (i < 8);
            drive_cycle(1'b0, '0, '0, exp_r, ADDR_W'(i), 1'b1, w_hs, r_hs, rsp_v, rsp_d, web, pend);
            checks++;
            if (r_hs !== exp_r) begin errors++; $display("FAIL stream_accept %0d got=%b exp=%b", i, r_hs, exp_r); end
            checks++;
            if (rsp_v !== (i >= 1 && i <= 8)) begin
                errors++;
                $display("FAIL stream_resp_valid %0d got=%b exp=%b", i, rsp_v, (i >= 1 && i <= 8));
            end else if (rsp_v) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (rsp_d !== exp_d) begin
                    errors++;
                    $display("FAIL stream_resp_data %0d got=%h exp=%h", i, rsp_d, exp_d);
                end
            end
        end
    endtask

    task automatic test_random_traffic();
        logic w_hs, r_hs, rsp_v, web, rr;
        logic wv = 1'b0, rv = 1'b0;
        logic [DATA_W-1:0] rsp_d, exp_d, wd;
        logic [ADDR_W-1:0] wa, ra;
        int pend;
        wa = '0; ra = '0; wd = '0;
        for (int n = 0; n < 420; n++) begin
            if (n < 400) begin
                if (!wv && ($urandom_range(0, 1) == 1)) begin wv = 1'b1; wa = 5'($urandom); wd = rand80(); end
                if (!rv && ($urandom_range(0, 2) != 0)) begin rv = 1'b1; ra = 5'($urandom); end
                rr = ($urandom_range(0, 3) != 0);
            end else begin
                rr = 1'b1;
            end
            drive_cycle(wv, wa, wd, rv, ra, rr, w_hs, r_hs, rsp_v, rsp_d, web, pend);
            checks++;
            if (rsp_v !== (pend != 0)) begin
                errors++;
                $display("FAIL rand_resp_valid cycle %0d got=%b exp=%b", n, rsp_v, pend != 0);
            end else if (rsp_v && rr) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (rsp_d !== exp_d) begin
                    errors++;
                    $display("FAIL rand_resp_data cycle %0d got=%h exp=%h", n, rsp_d, exp_d);
                end
            end
            if (w_hs) wv = 1'b0;
            if (r_hs) rv = 1'b0;
        end
        checks++;
        if (wv || rv || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got wr_pend=%b rd_pend=%b resp_pend=%0d exp 0 0 0", wv, rv, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_response();
        logic w_hs, r_hs, rsp_v, web;
        logic [DATA_W-1:0] rsp_d;
        int pend;
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd4, 1'b0, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, w_hs, r_hs, rsp_v, rsp_d, web, pend);
        checks++;
        if (rsp_v !== 1'b1) begin errors++; $display("FAIL rst_mid_pending got=%b exp=1", rsp_v); end
        bus.wr_valid = 1'b1;
        bus.rd_valid = 1'b1;
        RSTB = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || SRAM_CEB !== 1'b1 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_immediate got valid=%b ceb=%b wr_rdy=%b exp 0 1 0",
                     bus.resp_valid, SRAM_CEB, bus.wr_ready);
        end
        exp_q.delete();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RSTB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_no_stale cycle %0d got=%b exp=0", i, bus.resp_valid);
            end
`ifdef SRAM_RESET_INIT_EN
            checks++;
            if (SRAM_CEB !== 1'b0 || SRAM_WEB !== 1'b0 || SRAM_A !== ADDR_W'(i) || init_done !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_sweep cycle %0d got ceb=%b web=%b a=%0d done=%b exp 0 0 %0d 0",
                         i, SRAM_CEB, SRAM_WEB, SRAM_A, init_done, i);
            end
`else
            checks++;
            if (init_done !== 1'b1 || SRAM_CEB !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_run cycle %0d got done=%b ceb=%b exp 1 1", i, init_done, SRAM_CEB);
            end
`endif
        end
    endtask

    initial begin
        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_addr    = '0;
        bus.resp_ready = 1'b1;
        test_reset();
        test_release();
        test_fill();
        test_write_read();
        test_backpressure();
        test_arbitration();
        test_streaming();
        test_random_traffic();
        test_reset_mid_response();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
